// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges pipeline results with queued MDU results.
// Optional macro RF_WR_ARB_BYPASS_EN lets an MDU result skip an empty FIFO.
module rf_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              pipe_valid_i,
  input  logic [4:0]                        pipe_rd_addr_i,
  input  logic [31:0]                       pipe_data_i,
  output logic                              pipe_ready_o,
  input  logic                              mdu_valid_i,
  input  logic [4:0]                        mdu_rd_addr_i,
  input  logic [31:0]                       mdu_data_i,
  output logic                              mdu_ready_o,
  output logic                              write_en_o,
  output logic [4:0]                        rd_addr_o,
  output logic [31:0]                       rd_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t         mem [FIFO_DEPTH];
  logic [PW-1:0]   rptr, wptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;

  logic    empty, full, forced_drain, pipe_hit, pipe_wr, deq;
  logic    mdu_acc, mdu_keep, byp, enq, sel_wr;
  wr_req_t sel;

  assign empty        = (count == '0);
  assign full         = (count == CW'(FIFO_DEPTH));
  assign forced_drain = !empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign pipe_hit     = pipe_valid_i && (pipe_rd_addr_i != '0);
  assign pipe_wr      = pipe_hit && !forced_drain;
  // x0 pipeline requests never claim the slot, so the head can drain alongside them.
  assign deq          = !empty && !pipe_wr;
  assign mdu_acc      = mdu_valid_i && !full;
  assign mdu_keep     = mdu_acc && (mdu_rd_addr_i != '0);
`ifdef RF_WR_ARB_BYPASS_EN
  assign byp          = mdu_keep && empty && !pipe_hit;
`else
  assign byp          = 1'b0;
`endif
  assign enq          = mdu_keep && !byp;

  assign pipe_ready_o = !forced_drain;
  assign mdu_ready_o  = !full;
  assign fifo_count_o = count;

  always_comb begin
    sel_wr = 1'b1;
    sel    = mem[rptr];
    if (pipe_wr)  sel = '{rd: pipe_rd_addr_i, data: pipe_data_i};
    else if (deq) sel = mem[rptr];
    else if (byp) sel = '{rd: mdu_rd_addr_i, data: mdu_data_i};
    else          sel_wr = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= '{rd: mdu_rd_addr_i, data: mdu_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      write_en_o <= 1'b0;
      rd_addr_o  <= '0;
      rd_data_o  <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (empty || deq)                       starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
      write_en_o <= sel_wr;
      if (sel_wr) begin
        rd_addr_o <= sel.rd;
        rd_data_o <= sel.data;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic against a queue model.
module tb_rf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, mdu_valid;
  logic [4:0]  pipe_rd, mdu_rd;
  logic [31:0] pipe_data, mdu_data;
  logic        pipe_ready, mdu_ready, write_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .pipe_valid_i(pipe_valid), .pipe_rd_addr_i(pipe_rd), .pipe_data_i(pipe_data),
    .pipe_ready_o(pipe_ready),
    .mdu_valid_i(mdu_valid), .mdu_rd_addr_i(mdu_rd), .mdu_data_i(mdu_data),
    .mdu_ready_o(mdu_ready),
    .write_en_o(write_en), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .fifo_count_o(fifo_count)
  );

  // Reference model: pending MDU results as a queue, head wait as a cycle count.
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        q[$];
  int          m_blocked = 0;
  logic        m_en = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk) begin
    int n;
    bit forced, popped, bypassed;
    ent_t e;
    if (rst) begin
      q.delete(); m_blocked = 0; m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      n = q.size(); forced = (n > 0) && (m_blocked >= LIMIT);
      popped = 0; bypassed = 0; m_en = 1'b1;
      if (!forced && pipe_valid && pipe_rd != 0) begin
        m_addr = pipe_rd; m_data = pipe_data;
      end else if (n > 0) begin
        e = q.pop_front(); m_addr = e.rd; m_data = e.d; popped = 1;
      end
`ifdef RF_WR_ARB_BYPASS_EN
      else if (mdu_valid && mdu_rd != 0) begin
        m_addr = mdu_rd; m_data = mdu_data; bypassed = 1;
      end
`endif
      else m_en = 1'b0;
      if (n == 0 || popped) m_blocked = 0;
      else if (m_blocked < LIMIT) m_blocked = m_blocked + 1;
      if (mdu_valid && n < DEPTH && mdu_rd != 0 && !bypassed) begin
        e.rd = mdu_rd; e.d = mdu_data; q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (write_en === 1'b1 && rd_addr === 5'd0) begin
        errors++; $display("FAIL x0_invariant: write_en=1 rd_addr=%0d, required no write to x0", rd_addr);
      end
    end
  end

  task automatic idle();
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
  endtask

  task automatic pulse_reset();
    idle(); rst = 1; @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    repeat (2) @(negedge clk);
    checks += 6;
    if (write_en !== 1'b0)   begin errors++; $display("FAIL reset_we: got %b want 0", write_en); end
    if (rd_addr !== 5'd0)    begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
    if (rd_data !== 32'd0)   begin errors++; $display("FAIL reset_data: got %h want 0", rd_data); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    if (pipe_ready !== 1'b1) begin errors++; $display("FAIL reset_pready: got %b want 1", pipe_ready); end
    if (mdu_ready !== 1'b1)  begin errors++; $display("FAIL reset_mready: got %b want 1", mdu_ready); end
    rst = 0;
  endtask

  task automatic test_pipe_only();
    idle(); @(negedge clk);
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
    checks++;
    if (pipe_ready !== 1'b1) begin errors++; $display("FAIL pipe_ready_n: got %b want 1", pipe_ready); end
    @(negedge clk); idle();
    checks += 4;
    if (write_en !== 1'b1)         begin errors++; $display("FAIL pipe_we: got %b want 1", write_en); end
    if (rd_addr !== 5'd5)          begin errors++; $display("FAIL pipe_addr: got %0d want 5", rd_addr); end
    if (rd_data !== 32'hDEADBEEF)  begin errors++; $display("FAIL pipe_data: got %h want deadbeef", rd_data); end
    if (pipe_ready !== 1'b1)       begin errors++; $display("FAIL pipe_ready_n1: got %b want 1", pipe_ready); end
  endtask

  task automatic test_x0_filter();
    idle(); @(negedge clk);
    pipe_valid = 1; pipe_rd = 0; pipe_data = 32'h1234;
    @(negedge clk); idle();
    checks++;
    if (write_en !== 1'b0) begin errors++; $display("FAIL x0_pipe_we: got %b want 0", write_en); end
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h5555;
    checks++;
    if (mdu_ready !== 1'b1) begin errors++; $display("FAIL x0_mdu_ready: got %b want 1", mdu_ready); end
    @(negedge clk); idle();
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL x0_mdu_count: got %0d want 0", fifo_count); end
    @(negedge clk);
    checks++;
    if (write_en !== 1'b0) begin errors++; $display("FAIL x0_mdu_we: got %b want 0", write_en); end
  endtask

  task automatic test_fifo_full_starve();
    int t;
    pulse_reset();
    pipe_valid = 1; pipe_rd = 3;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mdu_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %b want 1", k, mdu_ready); end
      mdu_valid = 1; mdu_rd = 5'(10 + k); mdu_data = 32'hC0DE0000 + k; pipe_data = $urandom;
      @(negedge clk);
    end
    t = 3;
    checks += 2;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
    if (mdu_ready !== 1'b0)  begin errors++; $display("FAIL full_ready4: got %b want 0", mdu_ready); end
    mdu_rd = 5'd20; mdu_data = 32'hBADBAD00;
    @(negedge clk); t++;
    mdu_valid = 0;
    while (pipe_ready === 1'b1 && t < 40) begin
      pipe_data = $urandom; @(negedge clk); t++;
    end
    checks += 2;
    if (t !== LIMIT)         begin errors++; $display("FAIL starve_time: got %0d want %0d", t, LIMIT); end
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL starve_count_pre: got %0d want 4", fifo_count); end
    @(negedge clk);
    checks += 5;
    if (write_en !== 1'b1)          begin errors++; $display("FAIL starve_we: got %b want 1", write_en); end
    if (rd_addr !== 5'd10)          begin errors++; $display("FAIL starve_addr: got %0d want 10", rd_addr); end
    if (rd_data !== 32'hC0DE0000)   begin errors++; $display("FAIL starve_data: got %h want c0de0000", rd_data); end
    if (fifo_count !== 3'd3)        begin errors++; $display("FAIL starve_count: got %0d want 3", fifo_count); end
    if (pipe_ready !== 1'b1)        begin errors++; $display("FAIL starve_pready: got %b want 1", pipe_ready); end
    idle(); repeat (6) @(negedge clk);
  endtask

  task automatic test_x0_share();
    pulse_reset();
    pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h33;
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hA5A5A5A5;
    @(negedge clk);
    mdu_valid = 0; pipe_rd = 0; pipe_data = 32'h1234;
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL share_count_pre: got %0d want 1", fifo_count); end
    @(negedge clk); idle();
    checks += 4;
    if (write_en !== 1'b1)        begin errors++; $display("FAIL share_we: got %b want 1", write_en); end
    if (rd_addr !== 5'd7)         begin errors++; $display("FAIL share_addr: got %0d want 7", rd_addr); end
    if (rd_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL share_data: got %h want a5a5a5a5", rd_data); end
    if (fifo_count !== 3'd0)      begin errors++; $display("FAIL share_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    pipe_valid = 1; pipe_rd = 3;
    for (int k = 0; k < 3; k++) begin
      mdu_valid = 1; mdu_rd = 5'(1 + k); mdu_data = $urandom; pipe_data = $urandom;
      @(negedge clk);
    end
    checks++;
    if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_count_pre: got %0d want 3", fifo_count); end
    idle(); rst = 1; @(negedge clk); rst = 0;
    checks += 2;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
    if (write_en !== 1'b0)   begin errors++; $display("FAIL mid_we: got %b want 0", write_en); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (write_en !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got we=%b rd=%0d want 0", i, write_en, rd_addr); end
    end
  endtask

  task automatic test_bypass_latency();
    pulse_reset(); @(negedge clk);
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99990001;
    @(negedge clk); idle();
`ifdef RF_WR_ARB_BYPASS_EN
    checks += 3;
    if (write_en !== 1'b1)   begin errors++; $display("FAIL byp_we: got %b want 1", write_en); end
    if (rd_addr !== 5'd9)    begin errors++; $display("FAIL byp_addr: got %0d want 9", rd_addr); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL byp_count: got %0d want 0", fifo_count); end
`else
    checks += 2;
    if (write_en !== 1'b0)   begin errors++; $display("FAIL lat_we1: got %b want 0", write_en); end
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL lat_count1: got %0d want 1", fifo_count); end
    @(negedge clk);
    checks += 4;
    if (write_en !== 1'b1)        begin errors++; $display("FAIL lat_we2: got %b want 1", write_en); end
    if (rd_addr !== 5'd9)         begin errors++; $display("FAIL lat_addr: got %0d want 9", rd_addr); end
    if (rd_data !== 32'h99990001) begin errors++; $display("FAIL lat_data: got %h want 99990001", rd_data); end
    if (fifo_count !== 3'd0)      begin errors++; $display("FAIL lat_count2: got %0d want 0", fifo_count); end
`endif
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      pipe_valid = ($urandom_range(0, 99) < 55);
      pipe_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data  = $urandom;
      mdu_valid  = ($urandom_range(0, 99) < 45);
      mdu_rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdu_data   = $urandom;
      @(negedge clk);
      checks += 6;
      if (write_en !== m_en)     begin errors++; $display("FAIL rnd_we@%0d: got %b want %b", i, write_en, m_en); end
      if (rd_addr !== m_addr)    begin errors++; $display("FAIL rnd_addr@%0d: got %0d want %0d", i, rd_addr, m_addr); end
      if (rd_data !== m_data)    begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", i, rd_data, m_data); end
      if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, fifo_count, q.size()); end
      if (pipe_ready !== !(q.size() > 0 && m_blocked >= LIMIT))
        begin errors++; $display("FAIL rnd_pready@%0d: got %b want %b", i, pipe_ready, !(q.size() > 0 && m_blocked >= LIMIT)); end
      if (mdu_ready !== (q.size() < DEPTH))
        begin errors++; $display("FAIL rnd_mready@%0d: got %b want %b", i, mdu_ready, q.size() < DEPTH); end
    end
    rst = 0; idle();
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_pipe_only();
    test_x0_filter();
    test_fifo_full_starve();
    test_x0_share();
    test_reset_mid();
    test_bypass_latency();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
